// File: rtl/pipeline_sum_accumulator.sv
// Accumulates a programmed number of 9-bit adder results and presents the total on a
// valid/ready handshake. Define ACC_SATURATE_EN to clamp on overflow instead of wrapping.
module pipeline_sum_accumulator #(
    parameter int unsigned ACC_W = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] count_len,
    input  logic             in_valid,
    input  logic [7:0]       in_sum,
    input  logic             in_cout,
    output logic             busy,
    output logic             drop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf
);

    typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   target_q, target_d;
    logic               drop_q, drop_d;
    logic [ACC_W:0]     acc_sum;

    // One extra bit on top captures the carry out of the accumulator MSB.
    assign acc_sum = {1'b0, acc_q} + {{(ACC_W - 8){1'b0}}, in_cout, in_sum};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
            target_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            drop_q   <= drop_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        drop_d   = in_valid && (state_q != StAccum);

        case (state_q)
            StIdle: begin
                if (start && (count_len != '0)) begin
                    state_d  = StAccum;
                    acc_d    = '0;
                    ovf_d    = 1'b0;
                    cnt_d    = '0;
                    target_d = count_len;
                end
            end
            StAccum: begin
                if (in_valid) begin
                    cnt_d = cnt_q + CNT_W'(1);
`ifdef ACC_SATURATE_EN
                    if (ovf_q || acc_sum[ACC_W]) begin
                        acc_d = '1;
                        ovf_d = 1'b1;
                    end else begin
                        acc_d = acc_sum[ACC_W-1:0];
                    end
`else
                    acc_d = acc_sum[ACC_W-1:0];
                    ovf_d = ovf_q | acc_sum[ACC_W];
`endif
                    if (cnt_d == target_q) begin
                        state_d = StHold;
                    end
                end
            end
            // A start coinciding with the handshake is dropped: IDLE must be seen first.
            StHold: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy      = (state_q != StIdle);
    assign out_valid = (state_q == StHold);
    assign drop      = drop_q;
    assign out_acc   = acc_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_pipeline_sum_accumulator.sv
// Scoreboard bench for pipeline_sum_accumulator: expected totals are queued as samples are
// driven and checked when out_valid appears. Honors ACC_SATURATE_EN like the design.
module tb_pipeline_sum_accumulator;

    localparam int ACC_W   = 16;
    localparam int CNT_W   = 8;
    localparam int ACC_MAX = (1 << ACC_W) - 1;
`ifdef ACC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] count_len;
    logic             in_valid;
    logic [7:0]       in_sum;
    logic             in_cout;
    logic             busy;
    logic             drop;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic             out_ovf;

    pipeline_sum_accumulator #(
        .ACC_W(ACC_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .count_len(count_len),
        .in_valid (in_valid),
        .in_sum   (in_sum),
        .in_cout  (in_cout),
        .busy     (busy),
        .drop     (drop),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_acc  (out_acc),
        .out_ovf  (out_ovf)
    );

    always #5 clk = ~clk;

    int             n_checks = 0;
    int             n_fail   = 0;
    logic [ACC_W:0] exp_q[$];   // {ovf, acc}
    int             exp_acc;
    bit             exp_ovf;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int len);
        start     = 1'b1;
        count_len = len[CNT_W-1:0];
        tick();
        start   = 1'b0;
        exp_acc = 0;
        exp_ovf = 1'b0;
    endtask

    task automatic model_add(input logic [8:0] s);
        int t;
        t = exp_acc + int'(s);
        if (t > ACC_MAX) begin
            exp_ovf = 1'b1;
            t = SAT ? ACC_MAX : t - (ACC_MAX + 1);
        end
        if (SAT && exp_ovf) t = ACC_MAX;
        exp_acc = t;
    endtask

    task automatic send(input logic [8:0] s);
        in_valid           = 1'b1;
        {in_cout, in_sum}  = s;
        model_add(s);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic finish_run();
        exp_q.push_back({exp_ovf, exp_acc[ACC_W-1:0]});
    endtask

    task automatic wait_valid(output bit ok);
        int n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        ok = out_valid;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; count_len = '0; in_valid = 1'b0;
        in_sum = '0; in_cout = 1'b0; out_ready = 1'b0;
        #12;
        n_checks++;
        if ({busy, drop, out_valid, out_ovf, out_acc} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs busy=%b drop=%b valid=%b ovf=%b acc=%h required all 0",
                     busy, drop, out_valid, out_ovf, out_acc);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [ACC_W:0] exp;
        out_ready = 1'b1;
        do_start(3);
        send(9'h0FF); send(9'h101); send(9'h080);
        finish_run();
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_latency out_valid=%b required 1", out_valid);
        end
        exp = exp_q.pop_front();
        n_checks++;
        if ({out_ovf, out_acc} !== exp || out_acc !== 16'h0280) begin
            n_fail++;
            $display("FAIL basic_result got ovf=%b acc=%h required %h (0280)", out_ovf, out_acc, exp);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_acc !== 16'h0280) begin
            n_fail++;
            $display("FAIL basic_idle busy=%b valid=%b acc=%h required 0 0 0280",
                     busy, out_valid, out_acc);
        end
    endtask

    task automatic test_backpressure();
        logic [ACC_W:0] exp;
        out_ready = 1'b0;
        do_start(3);
        send(9'h0FF); send(9'h101); send(9'h080);
        finish_run();
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_acc !== exp_q[0][ACC_W-1:0]) begin
                n_fail++;
                $display("FAIL bp_hold cycle=%0d valid=%b acc=%h required 1 %h",
                         i, out_valid, out_acc, exp_q[0][ACC_W-1:0]);
            end
            tick();
        end
        out_ready = 1'b1;
        exp = exp_q.pop_front();
        n_checks++;
        if ({out_ovf, out_acc} !== exp) begin
            n_fail++;
            $display("FAIL bp_result got %h required %h", {out_ovf, out_acc}, exp);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release busy=%b valid=%b required 0 0", busy, out_valid);
        end
    endtask

    task automatic test_overflow();
        logic [ACC_W:0] exp;
        bit ok;
        out_ready = 1'b1;
        do_start(200);
        repeat (200) send(9'h1FF);
        finish_run();
        wait_valid(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL ovf_timeout out_valid=%b required 1", out_valid);
            exp_q.delete();
        end else begin
            exp = exp_q.pop_front();
            n_checks++;
            if ({out_ovf, out_acc} !== exp || out_ovf !== 1'b1) begin
                n_fail++;
                $display("FAIL ovf_result got ovf=%b acc=%h required %h", out_ovf, out_acc, exp);
            end
        end
        tick();
    endtask

    task automatic test_protocol();
        logic [ACC_W:0] exp;
        start = 1'b1; count_len = '0;
        tick();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_len busy=%b required 0", busy);
        end
        out_ready = 1'b0;
        do_start(3);
        send(9'h011);
        start = 1'b1; count_len = 8'd10;
        send(9'h022);
        start = 1'b0;
        send(9'h133);
        finish_run();
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL start_in_accum out_valid=%b required 1", out_valid);
        end
        exp = exp_q.pop_front();
        n_checks++;
        if ({out_ovf, out_acc} !== exp) begin
            n_fail++;
            $display("FAIL start_in_accum_result got %h required %h", {out_ovf, out_acc}, exp);
        end
        in_valid = 1'b1; in_sum = 8'h55; in_cout = 1'b0;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (drop !== 1'b1 || out_acc !== exp[ACC_W-1:0]) begin
            n_fail++;
            $display("FAIL drop_hold drop=%b acc=%h required 1 %h", drop, out_acc, exp[ACC_W-1:0]);
        end
        start = 1'b1; count_len = 8'd2; out_ready = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL start_with_handshake busy=%b valid=%b required 0 0", busy, out_valid);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_not_queued busy=%b required 0", busy);
        end
        in_valid = 1'b1; in_sum = 8'h42;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (drop !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_idle drop=%b busy=%b required 1 0", drop, busy);
        end
        tick();
        n_checks++;
        if (drop !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_pulse drop=%b required 0", drop);
        end
    endtask

    task automatic test_gaps();
        logic [ACC_W:0] exp;
        out_ready = 1'b1;
        do_start(4);
        for (int c = 1; c <= 9; c++) begin
            if (c == 1 || c == 4 || c == 5 || c == 9) send(9'h010);
            else tick();
            if (c == 8) begin
                n_checks++;
                if (out_valid !== 1'b0 || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL gaps_early valid=%b busy=%b required 0 1", out_valid, busy);
                end
            end
        end
        finish_run();
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL gaps_latency out_valid=%b required 1", out_valid);
        end
        exp = exp_q.pop_front();
        n_checks++;
        if ({out_ovf, out_acc} !== exp || out_acc !== 16'h0040) begin
            n_fail++;
            $display("FAIL gaps_result got %h required %h (0040)", {out_ovf, out_acc}, exp);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        logic [ACC_W:0] exp;
        out_ready = 1'b1;
        do_start(5);
        send(9'h0A5); send(9'h17E);
        rst = 1'b0;
        #1;
        n_checks++;
        if ({busy, drop, out_valid, out_ovf, out_acc} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid busy=%b drop=%b valid=%b ovf=%b acc=%h required all 0",
                     busy, drop, out_valid, out_ovf, out_acc);
        end
        #3;
        rst = 1'b1;
        tick();
        do_start(1);
        send(9'h005);
        finish_run();
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_rerun_valid out_valid=%b required 1", out_valid);
        end
        exp = exp_q.pop_front();
        n_checks++;
        if ({out_ovf, out_acc} !== exp || out_acc !== 16'h0005) begin
            n_fail++;
            $display("FAIL reset_rerun_result got %h required %h (0005)", {out_ovf, out_acc}, exp);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_protocol();
        test_gaps();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
